arm_imm_encoder: RTL and testbench
==================================

// Module: arm_imm_encoder
// PURPOSE
//  Iterative encoder: the inverse of the shifter-operand/offset decode path.
//  Takes a 32-bit constant and finds the canonical data-processing rotate-immediate
//  field {rot4,imm8}, or packs a byte branch offset into the 24-bit B/BL field.
//  Serves the instruction-generation/self-test path feeding IR; start/done handshake.
// PARAMETERS
//  (none) - widths fixed by the ARM encoding (32-bit value, 12-bit imm, 24-bit offset)
// PORTS
//  clk        in   1   rising-edge clock
//  reset_n    in   1   asynchronous active-low reset
//  start      in   1   request; sampled only in IDLE
//  mode       in   1   0 = DP rotate-immediate, 1 = branch offset
//  value      in   32  constant (mode 0) or signed byte offset target-(PC+8) (mode 1)
//  busy       out  1   high from edge after accepted start until done cycle (incl.)
//  done       out  1   one-cycle pulse: results valid
//  valid      out  1   1 = encodable; held until next accepted start
//  imm12      out  12  {rot4,imm8}; decoded value = imm8 ROR (2*rot4)
//  offset24   out  24  branch field = value[25:2]
//  carry_out  out  1   shifter carry of encoding: 0 if rot4==0, else decoded bit 31
//  inverted   out  1   1 = imm12 encodes ~value (MVN/BIC form); 0 without macro
// BEHAVIOUR
//  Reset (async, reset_n low): state IDLE; busy,done,valid,inverted,carry_out = 0;
//   imm12, offset24 = 0; rot counter = 0. Reset mid-search aborts, no done pulse.
//  States: IDLE -> SEARCH -> (INV_SEARCH, macro only) -> IDLE.
//  IDLE: start=1 at edge E0 -> latch value/mode, rot=0, busy=1, enter SEARCH.
//   start while busy is ignored (no queueing, latched value unchanged).
//  SEARCH mode 0: in cycle after edge Ek test cand = value ROL (2*k).
//   Hit if cand[31:8]==0 -> at edge E(k+1): imm12={k[3:0],cand[7:0]}, valid=1,
//   done=1 for one cycle, -> IDLE. Lowest rot wins (canonical; 0 -> imm12=0x000).
//   Miss at k=15 -> valid=0, imm12=0, done after E16 (macro off).
//   Latency = rot+1 cycles hit; 16 cycles fail.
//  SEARCH mode 1: fixed 1-cycle latency, done after E1.
//   valid = (value[1:0]==0) && (-2^25 <= signed value <= 2^25-4);
//   offset24 = value[25:2] when valid, else 0. imm12=0, carry_out=0.
//  Rotation uses explicit 32-bit concat; no sign extension; counter 4 bits, no wrap
//   beyond 15 (terminal compare, not overflow).
//  done and start same cycle in IDLE transition: new start accepted the cycle after
//   done (done cycle counts as busy).
// CONFIGURATION
//  ARM_IMM_INVERT_EN defined: on mode-0 miss at k=15, enter INV_SEARCH, repeat
//   search on ~value, rot restarted at 0; hit at k -> inverted=1, done after
//   E(17+k); fail -> done after E32, valid=0, inverted=0.
//  Undefined: INV_SEARCH absent, inverted tied 0, worst-case latency 16.
// TESTING
//  mode0 value=0x000000FF -> done after E1, valid=1, imm12=0x0FF, carry_out=0
//  mode0 value=0xFF000000 -> done after E5, imm12=0x4FF, carry_out=1
//  mode0 value=0x00000101 -> done after E16, valid=0, imm12=0x000 (macro off)
//  mode1 value=0xFFFFFFF8 -> offset24=0xFFFFFE valid=1; 0x02000000 and 0x00000006 -> valid=0
//  reset_n low at E3 of search -> all outputs 0 next cycle, no done; start at E2 ignored
//  ARM_IMM_INVERT_EN, value=0xFFFFFF00 -> done after E17, inverted=1, imm12=0x0FF

Source files
------------

// File: rtl/arm_imm_encoder.sv
// arm_imm_encoder: iterative search for the ARM rotate-immediate {rot4,imm8} of a constant, or B/BL offset packing.
// Define ARM_IMM_INVERT_EN to retry a failed rotate search on ~value (MVN/BIC form).
module arm_imm_encoder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [11:0] imm12,
    output logic [23:0] offset24,
    output logic        carry_out,
    output logic        inverted
);
`ifdef ARM_IMM_INVERT_EN
    typedef enum logic [1:0] {IDLE, SEARCH, INV_SEARCH} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEARCH} state_t;
`endif
    state_t      state_q, state_d;
    logic [3:0]  rot_q, rot_d;
    logic [31:0] value_q, value_d;
    logic        mode_q, mode_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        valid_q, valid_d;
    logic [11:0] imm12_q, imm12_d;
    logic [23:0] offset24_q, offset24_d;
    logic        carry_q, carry_d;
    logic        inverted_q, inverted_d;
    logic        inv_phase;
    logic [31:0] src, cand;
    logic [63:0] dbl;
    logic        hit, br_ok;
`ifdef ARM_IMM_INVERT_EN
    assign inv_phase = (state_q == INV_SEARCH);
`else
    assign inv_phase = 1'b0;
`endif
    // Rotate-left by 2*rot: undo the decode's rotate-right and look for a bare byte.
    assign src   = inv_phase ? ~value_q : value_q;
    assign dbl   = {src, src};
    assign cand  = dbl[6'd63 - {1'b0, rot_q, 1'b0} -: 32];
    assign hit   = (cand[31:8] == 24'h0);
    assign br_ok = (value_q[1:0] == 2'b00) && (value_q[31:25] == 7'h00 || value_q[31:25] == 7'h7f);
    always_comb begin
        state_d    = state_q;
        rot_d      = rot_q;
        value_d    = value_q;
        mode_d     = mode_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        valid_d    = valid_q;
        imm12_d    = imm12_q;
        offset24_d = offset24_q;
        carry_d    = carry_q;
        inverted_d = inverted_q;
        if (state_q == IDLE) begin
            if (done_q) begin
                busy_d = 1'b0;
            end else if (start && !busy_q) begin
                state_d    = SEARCH;
                rot_d      = 4'd0;
                value_d    = value;
                mode_d     = mode;
                busy_d     = 1'b1;
                valid_d    = 1'b0;
                imm12_d    = 12'h0;
                offset24_d = 24'h0;
                carry_d    = 1'b0;
                inverted_d = 1'b0;
            end
        end else if (mode_q) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            valid_d    = br_ok;
            offset24_d = br_ok ? value_q[25:2] : 24'h0;
        end else if (hit) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            valid_d    = 1'b1;
            imm12_d    = {rot_q, cand[7:0]};
            carry_d    = (rot_q != 4'd0) && src[31];
            inverted_d = inv_phase;
        end else if (rot_q != 4'd15) begin
            rot_d = rot_q + 4'd1;
        end else begin
`ifdef ARM_IMM_INVERT_EN
            if (!inv_phase) begin
                state_d = INV_SEARCH;
                rot_d   = 4'd0;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rot_q      <= 4'd0;
            value_q    <= 32'h0;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            imm12_q    <= 12'h0;
            offset24_q <= 24'h0;
            carry_q    <= 1'b0;
            inverted_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rot_q      <= rot_d;
            value_q    <= value_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            imm12_q    <= imm12_d;
            offset24_q <= offset24_d;
            carry_q    <= carry_d;
            inverted_q <= inverted_d;
        end
    end
    assign busy      = busy_q;
    assign done      = done_q;
    assign valid     = valid_q;
    assign imm12     = imm12_q;
    assign offset24  = offset24_q;
    assign carry_out = carry_q;
    assign inverted  = inverted_q;
endmodule

// File: tb/tb_arm_imm_encoder.sv
// tb_arm_imm_encoder: random + directed scoreboard bench; expectations come from a brute-force encoding search.
module tb_arm_imm_encoder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] value = 32'h0;
    logic        busy, done, valid, carry_out, inverted;
    logic [11:0] imm12;
    logic [23:0] offset24;

    arm_imm_encoder dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .value(value),
        .busy(busy), .done(done), .valid(valid), .imm12(imm12), .offset24(offset24),
        .carry_out(carry_out), .inverted(inverted)
    );

    always #5 clk = ~clk;

`ifdef ARM_IMM_INVERT_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif

    typedef struct {
        logic        v;
        logic [11:0] imm;
        logic [23:0] off;
        logic        c;
        logic        inv;
        int          done_cyc;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int s);
        return (s == 0) ? x : ((x >> s) | (x << (32 - s)));
    endfunction

    // Reference: try every (pass, rot, imm8) and keep the first that decodes to the target.
    function automatic exp_t model(input logic m, input logic [31:0] v, input int e0);
        exp_t        e;
        logic [31:0] t;
        longint      sv;
        bit          found;
        e = '{v: 1'b0, imm: 12'h0, off: 24'h0, c: 1'b0, inv: 1'b0, done_cyc: e0 + 1, val: v};
        if (m) begin
            sv = longint'(signed'(v));
            e.v = (sv % 4 == 0) && (sv >= -33554432) && (sv <= 33554428);
            e.off = e.v ? v[25:2] : 24'h0;
        end else begin
            e.done_cyc = e0 + 16 * NPASS;
            found = 1'b0;
            for (int p = 0; p < NPASS; p++) begin
                t = (p == 1) ? ~v : v;
                for (int r = 0; r < 16; r++)
                    for (int i = 0; i < 256; i++)
                        if (!found && ror(32'(i), 2 * r) == t) begin
                            found      = 1'b1;
                            e.v        = 1'b1;
                            e.imm      = {4'(r), 8'(i)};
                            e.inv      = (p == 1);
                            e.c        = (r != 0) && t[31];
                            e.done_cyc = e0 + 16 * p + r + 1;
                        end
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending request");
            end else begin
                mon_e = sb.pop_front();
                check("done_cycle", cyc, mon_e.done_cyc);
                check("valid", {31'h0, valid}, {31'h0, mon_e.v});
                check("imm12", {20'h0, imm12}, {20'h0, mon_e.imm});
                check("offset24", {8'h0, offset24}, {8'h0, mon_e.off});
                check("carry_out", {31'h0, carry_out}, {31'h0, mon_e.c});
                check("inverted", {31'h0, inverted}, {31'h0, mon_e.inv});
                check("busy_in_done", {31'h0, busy}, 32'h1);
                if (n_fail != 0 && sb.size() < 2) $display("  for value 0x%0h", mon_e.val);
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_done"}, {31'h0, done}, 32'h0);
        check({tag, "_valid"}, {31'h0, valid}, 32'h0);
        check({tag, "_imm12"}, {20'h0, imm12}, 32'h0);
        check({tag, "_offset24"}, {8'h0, offset24}, 32'h0);
        check({tag, "_carry"}, {31'h0, carry_out}, 32'h0);
        check({tag, "_inverted"}, {31'h0, inverted}, 32'h0);
    endtask

    task automatic issue(input logic m, input logic [31:0] v, input bit b2b);
        int t;
        int e0;
        t = 0;
        while (busy && !(b2b && done) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got busy=1 after 200 cycles expected idle");
        end
        e0 = busy ? cyc + 2 : cyc + 1;
        start = 1'b1;
        mode  = m;
        value = v;
        sb.push_back(model(m, v, e0));
        while (cyc < e0) begin
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        value = $urandom;
        if ($urandom_range(0, 2) == 0 && busy) begin
            start = 1'b1;
            mode  = ~m;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    logic [31:0] directed_v[10] = '{32'h000000FF, 32'hFF000000, 32'h00000101, 32'h00000000, 32'hFFFFFF00,
                                   32'hFFFFFFF8, 32'h02000000, 32'h00000006, 32'hFE000000, 32'h01FFFFFC};
    logic        directed_m[10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};

    initial begin
        logic [31:0] v;
        logic        m;
        int          t;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        start = 1'b1;
        mode  = 1'b0;
        value = 32'h00000101;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        value = 32'h000000FF;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_mid_search", {31'h0, busy}, 32'h1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check_zero("abort");
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) issue(directed_m[i], directed_v[i], 1'b0);
        for (int i = 0; i < 150; i++) begin
            m = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: v = ror(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
                1: v = ~ror(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
                2: v = ror(32'($urandom_range(0, 255)), $urandom_range(0, 31));
                default: v = $urandom;
            endcase
            if (m && v[0]) begin
                v = $urandom & 32'h03FFFFFC;
                v = {{6{v[25]}}, v[25:0]};
            end
            issue(m, v, $urandom_range(0, 1) == 1);
        end
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
